// File: rtl/ifetch_if.sv
// Fetch-stage bundle: imem address/data, execute redirect, decode handshake and perf taps.
// master is the fetch stage itself; slave is the surrounding memory/decode/execute side.
interface ifetch_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic [AWIDTH-1:0] imem_addr;
  logic [DWIDTH-1:0] imem_dout;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [DWIDTH-1:0] out_instr;
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stalls;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, perf_fetched, perf_stalls,
    input  imem_dout, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, perf_fetched, perf_stalls,
    output imem_dout, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: owns fetch PC, captures async imem data into a 2-entry buffer for decode.
// Optional perf counters built when IFETCH_PERF_EN is defined; otherwise they read as 0.
module ifetch #(
  parameter int          DWIDTH   = 32,
  parameter int          AWIDTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       head_pc_q, tail_pc_q;
  logic [DWIDTH-1:0] head_instr_q, tail_instr_q;
  logic              deq, enq;
  logic              unused_pc_lsbs;

  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

  assign deq = bus.out_valid && bus.out_ready;
  // Enqueue looks at the pre-dequeue occupancy, so FULL never accepts even when draining.
  assign enq = !bus.redirect_valid && (state_q != FULL);

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (enq) state_d = ONE;
        ONE: begin
          if (enq && !deq)      state_d = FULL;
          else if (!enq && deq) state_d = EMPTY;
        end
        FULL:    if (deq) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = (state_q != EMPTY);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (enq)           fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= {RESET_PC[31:2], 2'b00};
      head_pc_q    <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      case (state_q)
        EMPTY: if (enq) begin
          head_pc_q    <= fetch_pc_q;
          head_instr_q <= bus.imem_dout;
        end
        ONE: if (enq) begin
          if (deq) begin
            head_pc_q    <= fetch_pc_q;
            head_instr_q <= bus.imem_dout;
          end else begin
            tail_pc_q    <= fetch_pc_q;
            tail_instr_q <= bus.imem_dout;
          end
        end
        FULL: if (deq) begin
          head_pc_q    <= tail_pc_q;
          head_instr_q <= tail_instr_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr = fetch_pc_q[AWIDTH+1:2];
  assign bus.out_pc    = head_pc_q;
  assign bus.out_instr = head_instr_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (deq)                             fetched_q <= fetched_q + 32'd1;
      if (bus.out_valid && !bus.out_ready) stalls_q  <= stalls_q + 32'd1;
    end
  end

  assign bus.perf_fetched = fetched_q;
  assign bus.perf_stalls  = stalls_q;
`else
  assign bus.perf_fetched = '0;
  assign bus.perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: queue-based reference model checked every cycle plus directed literal pins.
module tb_ifetch;
  localparam int          DW = 32;
  localparam int          AW = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  logic [DW-1:0] mem [16];

  ifetch_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
  ifetch #(.DWIDTH(DW), .AWIDTH(AW), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.imem_dout = mem[bus.imem_addr];

  always #5 clk = ~clk;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched, m_stalls;
  bit          m_init = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: buffer as a queue of {pc,instr}, fetch PC as plain 32-bit arithmetic.
  always @(posedge clk) begin : model
    bit   was_full, d;
    ent_t e;
    if (rst) begin
      q.delete();
      m_pc      = {RPC[31:2], 2'b00};
      m_fetched = 0;
      m_stalls  = 0;
      m_init    = 1;
    end else if (m_init) begin
      was_full = (q.size() == 2);
      d        = (q.size() > 0) && bus.out_ready;
      if (d) m_fetched = m_fetched + 1;
      if (q.size() > 0 && !bus.out_ready) m_stalls = m_stalls + 1;
      if (bus.redirect_valid) begin
        q.delete();
        m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (d) void'(q.pop_front());
        if (!was_full) begin
          e.pc    = m_pc;
          e.instr = mem[m_pc[AW+1:2]];
          q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (m_init) begin
      chk("model_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
      chk("model_addr", {28'd0, bus.imem_addr}, {28'd0, m_pc[AW+1:2]});
      if (q.size() > 0) begin
        chk("model_pc", bus.out_pc, q[0].pc);
        chk("model_instr", bus.out_instr, q[0].instr);
      end
`ifdef IFETCH_PERF_EN
      chk("model_fetched", bus.perf_fetched, m_fetched);
      chk("model_stalls", bus.perf_stalls, m_stalls);
`else
      chk("model_fetched", bus.perf_fetched, 32'd0);
      chk("model_stalls", bus.perf_stalls, 32'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input logic [31:0] pc, input logic [31:0] instr);
    chk("lit_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lit_pc", bus.out_pc, pc);
    chk("lit_instr", bus.out_instr, instr);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
    chk("redir_bubble", {31'd0, bus.out_valid}, 32'd0);
    step();
  endtask

  task automatic perf_lit(input logic [31:0] f, input logic [31:0] s);
`ifdef IFETCH_PERF_EN
    chk("lit_fetched", bus.perf_fetched, f);
    chk("lit_stalls", bus.perf_stalls, s);
`else
    chk("lit_fetched", bus.perf_fetched, 32'd0);
    chk("lit_stalls", bus.perf_stalls, 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = i;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_addr", {28'd0, bus.imem_addr}, 32'd0);
    perf_lit(32'd0, 32'd0);

    // Continuous fetch, then 3 cycles of backpressure after (0,0) goes out.
    rst = 1'b0;
    step();
    lit(32'd0, 32'd0);
    step();
    lit(32'd4, 32'd1);
    bus.out_ready = 1'b0;
    step();
    lit(32'd4, 32'd1);
    chk("full_addr", {28'd0, bus.imem_addr}, 32'd3);
    step();
    lit(32'd4, 32'd1);
    chk("full_addr", {28'd0, bus.imem_addr}, 32'd3);
    step();
    lit(32'd4, 32'd1);
    bus.out_ready = 1'b1;
    step();
    lit(32'd8, 32'd2);
    step();
    lit(32'd12, 32'd3);
    perf_lit(32'd3, 32'd3);

    // Fill to FULL, then redirect to 8.
    bus.out_ready = 1'b0;
    step();
    chk("full_addr2", {28'd0, bus.imem_addr}, 32'd5);
    redirect(32'h0000_0008);
    bus.out_ready = 1'b1;
    lit(32'd8, 32'd2);
    step();
    lit(32'd12, 32'd3);

    redirect(32'h0000_000E);
    lit(32'h0000_000C, 32'd3);

    redirect(32'h0000_003C);
    lit(32'h0000_003C, 32'd15);
    chk("wrap_addr", {28'd0, bus.imem_addr}, 32'd0);
    step();
    lit(32'h0000_0040, 32'd0);

    redirect(32'hFFFF_FFFC);
    lit(32'hFFFF_FFFC, 32'd15);
    step();
    lit(32'h0000_0000, 32'd0);

    // Randomized traffic: random memory, ready, redirects and occasional resets.
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = $urandom;
      rst                = ($urandom_range(0, 199) == 0);
      if (n % 500 == 0) mem[$urandom_range(0, 15)] = $urandom;
      step();
    end

    // Reset while FULL after 3 stalled cycles.
    for (int i = 0; i < 16; i++) mem[i] = i;
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    lit(32'd0, 32'd0);
    bus.out_ready = 1'b0;
    step();
    step();
    step();
    lit(32'd0, 32'd0);
    chk("pre_rst_addr", {28'd0, bus.imem_addr}, 32'd2);
    perf_lit(32'd0, 32'd3);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_addr", {28'd0, bus.imem_addr}, 32'd0);
    perf_lit(32'd0, 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    lit(32'd0, 32'd0);
    step();
    lit(32'd4, 32'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the SimpleRV core. It sits directly upstream of `imem`: it owns the fetch PC, drives the memory's word address, and captures the combinational `imem` read data. It delivers `{pc, instr}` pairs to decode over a valid/ready handshake. Decode backpressure is absorbed by a 2-entry buffer, and the execute stage can redirect fetch on branches and jumps.

## Interface
- `DWIDTH`, 32: instruction width; must match `imem`.
- `AWIDTH`, 4: `imem` word-address width; memory holds 2**AWIDTH words.
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset; bits [1:0] ignored.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset (see clock and reset line above).
- `imem_addr`  out  AWIDTH: word address to `imem`, equal to `fetch_pc[AWIDTH+1:2]`; combinational from the fetch-PC register.
- `imem_dout`  in  DWIDTH: `imem` asynchronous read data for `imem_addr`.
- `redirect_valid`  in  1: flush and reload the fetch PC this cycle.
- `redirect_pc`  in  32: new byte-address PC; bits [1:0] forced to 0.
- `out_valid`  out  1: buffer head holds a valid instruction.
- `out_ready`  in  1: decode accepts the head this cycle.
- `out_pc`  out  32: byte PC of the head instruction.
- `out_instr`  out  DWIDTH: head instruction word.
- `perf_fetched`  out  32: instructions handed to decode (see Configuration).
- `perf_stalls`  out  32: cycles with `out_valid && !out_ready` (see Configuration).

## Operation
- State is the buffer occupancy: EMPTY (0), ONE (1), FULL (2). `out_valid` is 1 when the state is not EMPTY.
- Dequeue (`deq`) = `out_valid && out_ready`. It removes the head, and entries stay in order.
- Enqueue (`enq`) = `!redirect_valid && state != FULL`, evaluated on the pre-dequeue state. It writes `{fetch_pc, imem_dout}` at the tail and advances `fetch_pc` by 4.
- Transitions when there is no redirect:
  - EMPTY: `enq` moves to ONE.
  - ONE: `enq && deq` stays in ONE; `enq` only moves to FULL.
  - FULL: `deq` moves to ONE. Nothing is enqueued in FULL, so `fetch_pc` holds.
- Redirect has priority over everything. The next state is EMPTY, `fetch_pc <= {redirect_pc[31:2], 2'b00}`, and no enqueue happens. A same-cycle dequeue is still reported as a handshake, but its entry is discarded along with the rest.
- `fetch_pc` is 32 bits and wraps modulo 2**32: 32'hFFFF_FFFC + 4 = 0.
- `imem_addr` is a truncation of `fetch_pc`, so it wraps modulo 2**AWIDTH. `out_pc` keeps the full 32-bit value.
- Steady state with `out_ready` held at 1 is ONE, giving 1 instruction per cycle.

## Timing
- Reset values:
  - `fetch_pc` = `{RESET_PC[31:2], 2'b00}`, so `imem_addr` = `RESET_PC[AWIDTH+1:2]`.
  - State EMPTY, `out_valid` = 0.
  - `out_pc` = 0, `out_instr` = 0 (buffer entries cleared), perf counters = 0.
- Reset asserted mid-operation: all of the above applies at the next edge, and buffered entries are lost.
- Fetch latency: the address driven in cycle N is captured at the edge ending N and appears on `out_*` in cycle N+1.
  - First cycle after `rst` falls: fetches `RESET_PC`; `out_valid` = 1 the following cycle.
- Redirect sampled in cycle N:
  - Cycle N+1: `imem_addr` = target and `out_valid` = 0.
  - Cycle N+2: target instruction is on `out_*`.
- `out_*` are driven only from buffer registers, so there is no combinational path from `imem_dout` or `out_ready` to `out_*`.
- `out_pc` and `out_instr` hold stable while `out_valid && !out_ready`.

## Configuration
- `IFETCH_PERF_EN` defined:
  - `perf_fetched` increments on every `deq`.
  - `perf_stalls` increments on every cycle with `out_valid && !out_ready`.
  - Both are 32-bit, wrap, and clear on `rst`.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Continuous fetch: `imem` loaded with mem[i]=i, `out_ready`=1 → from the second cycle after reset, (`out_pc`, `out_instr`) = (0,0), (4,1), (8,2), … one per cycle.
- Backpressure: drop `out_ready` for 3 cycles after (0,0) is delivered.
  - State reaches FULL holding pc 4 and 8; `imem_addr` holds at 3.
  - On release, delivery resumes 4, 8, 12 with no drop or duplicate.
- Redirect while FULL: `redirect_pc`=32'h0000_0008 → `out_valid`=0 for one cycle, then (8,2), (12,3).
- Misaligned redirect: `redirect_pc`=32'h0000_000E → first delivered pair is (32'hC, 3).
- Wrap: `AWIDTH`=4, redirect to 32'h3C → (32'h3C, 15), then (32'h40, 0) with `imem_addr`=0.
- Reset mid-stream while FULL with `IFETCH_PERF_EN` defined:
  - Next cycle: `out_valid`=0 and both perf counters = 0.
  - After reset is released: fetch restarts at `RESET_PC`.
  - Before the reset, `perf_stalls` equals the number of stalled cycles driven.
